// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: pixel-stream sequencer for the Sobel line buffers and 3x3 window
//
// Ports:
//     clk, rst       clock, asynchronous active-high reset
//     start_i        one-cycle pulse that arms a frame (honoured only when idle)
//     valid_i        pixel strobe from the source
//     busy_o         a frame is in progress
//     lb_we_o        [0] line buffer 0 write enable, [1] line buffer 1 write enable
//     win_valid_o    the 3x3 window is valid this cycle
//     row_o, col_o   window centre coordinates
//     pad_mask_o     {top, bottom, left, right} border flags of the window centre
//     frame_done_o   one-cycle end-of-frame pulse, aligned with the final window
//
// Build option: define LBC_BORDER_EN for full-frame mode (one window per pixel,
// drained by a FLUSH phase). Without it only interior windows are produced.
module line_buffer_ctrl #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int CW     = $clog2(WIDTH),
    parameter int RW     = $clog2(HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          valid_i,
    output logic          busy_o,
    output logic [1:0]    lb_we_o,
    output logic          win_valid_o,
    output logic [RW-1:0] row_o,
    output logic [CW-1:0] col_o,
    output logic [3:0]    pad_mask_o,
    output logic          frame_done_o
);
    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] in_col_q, col_d;
    logic [RW-1:0] in_row_q, row_d;
    logic          accept, col_last, frame_last, arm;
    logic          win_d, done_d, busy_d;
    logic [1:0]    we_d;
    logic [3:0]    pad_d;
`ifdef LBC_BORDER_EN
    logic [CW-1:0] out_col_q;
    logic [RW-1:0] out_row_q;
    logic          strobe;
`endif

    always_comb begin
        arm        = state_q == IDLE && start_i;
        accept     = valid_i && (state_q == FILL || state_q == RUN);
        col_last   = in_col_q == COL_MAX;
        frame_last = accept && col_last && in_row_q == ROW_MAX;
`ifdef LBC_BORDER_EN
        // Windows lag the input by WIDTH+1 pixels; the flush strobes drain the tail.
        strobe  = state_q == FLUSH;
        win_d   = strobe || (accept && (in_row_q > RW'(1) || (in_row_q == RW'(1) && in_col_q != '0)));
        row_d   = win_d ? out_row_q : '0;
        col_d   = win_d ? out_col_q : '0;
        pad_d   = win_d ? {out_row_q == '0, out_row_q == ROW_MAX, out_col_q == '0, out_col_q == COL_MAX} : 4'b0;
        done_d  = strobe && out_row_q == ROW_MAX && out_col_q == COL_MAX;
        we_d    = strobe ? 2'b11 : {accept && in_row_q != '0, accept};
        state_d = arm ? FILL :
                  (state_q == FILL && accept && col_last) ? RUN :
                  frame_last ? FLUSH :
                  done_d ? IDLE : state_q;
`else
        // Columns 0 and 1 never complete a window, so nothing straddles a line wrap.
        win_d   = accept && in_row_q >= RW'(2) && in_col_q >= CW'(2);
        row_d   = win_d ? in_row_q - RW'(1) : '0;
        col_d   = win_d ? in_col_q - CW'(1) : '0;
        pad_d   = 4'b0;
        done_d  = frame_last;
        we_d    = {accept && in_row_q != '0, accept};
        state_d = arm ? FILL :
                  (state_q == FILL && accept && col_last) ? RUN :
                  frame_last ? IDLE : state_q;
`endif
        // Busy holds through the frame_done cycle and drops on the one after.
        busy_d = state_d != IDLE || done_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            in_col_q     <= '0;
            in_row_q     <= '0;
            busy_o       <= 1'b0;
            lb_we_o      <= 2'b0;
            win_valid_o  <= 1'b0;
            row_o        <= '0;
            col_o        <= '0;
            pad_mask_o   <= 4'b0;
            frame_done_o <= 1'b0;
`ifdef LBC_BORDER_EN
            out_col_q    <= '0;
            out_row_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            busy_o       <= busy_d;
            lb_we_o      <= we_d;
            win_valid_o  <= win_d;
            row_o        <= row_d;
            col_o        <= col_d;
            pad_mask_o   <= pad_d;
            frame_done_o <= done_d;
            if (arm) begin
                in_col_q <= '0;
                in_row_q <= '0;
            end else if (accept) begin
                in_col_q <= col_last ? '0 : in_col_q + CW'(1);
                in_row_q <= col_last ? in_row_q + RW'(1) : in_row_q;
            end
`ifdef LBC_BORDER_EN
            if (arm) begin
                out_col_q <= '0;
                out_row_q <= '0;
            end else if (win_d) begin
                out_col_q <= out_col_q == COL_MAX ? '0 : out_col_q + CW'(1);
                out_row_q <= out_col_q == COL_MAX ? out_row_q + RW'(1) : out_row_q;
            end
`endif
        end
    end
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb_line_buffer_ctrl: directed checks of the line buffer sequencer at WIDTH=5, HEIGHT=4
module tb_line_buffer_ctrl;
    localparam int W = 5;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst, start_i, valid_i;
    logic       busy_o, win_valid_o, frame_done_o;
    logic [1:0] lb_we_o;
    logic [1:0] row_o;
    logic [2:0] col_o;
    logic [3:0] pad_mask_o;

    line_buffer_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .valid_i(valid_i),
        .busy_o(busy_o), .lb_we_o(lb_we_o), .win_valid_o(win_valid_o),
        .row_o(row_o), .col_o(col_o), .pad_mask_o(pad_mask_o),
        .frame_done_o(frame_done_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int npix = 0;
    int win_cnt = 0, we0_cnt = 0, we1_cnt = 0, we11_cnt = 0, done_cnt = 0;
    int idle_we_cnt = 0, seq_err = 0;
    int w_row[256], w_col[256], w_pad[256], w_done[256], w_pix[256];
    logic prev_done = 1'b0;

    // Event log sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (prev_done && busy_o) seq_err++;
        if (frame_done_o && (!busy_o || !win_valid_o)) seq_err++;
        prev_done = frame_done_o;
        if (lb_we_o[0]) we0_cnt++;
        if (lb_we_o[1]) we1_cnt++;
        if (lb_we_o == 2'b11) we11_cnt++;
        if (lb_we_o != 2'b00 && !busy_o) idle_we_cnt++;
        if (frame_done_o) done_cnt++;
        if (win_valid_o) begin
            if (win_cnt < 256) begin
                w_row[win_cnt]  = int'(row_o);
                w_col[win_cnt]  = int'(col_o);
                w_pad[win_cnt]  = int'(pad_mask_o);
                w_done[win_cnt] = int'(frame_done_o);
                w_pix[win_cnt]  = npix;
            end
            win_cnt++;
        end
    end

    task automatic do_start();
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        npix = 0;
    endtask

    // Drives n pixels; gap inserts an idle cycle after each; start_at raises start_i with that pixel.
    task automatic drive_pix(input int n, input bit gap, input int start_at);
        for (int i = 1; i <= n; i++) begin
            valid_i = 1'b1;
            start_i = (i == start_at);
            @(posedge clk); #1;
            npix++;
            start_i = 1'b0;
            if (gap) begin
                valid_i = 1'b0;
                @(posedge clk); #1;
            end
        end
        valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({busy_o, lb_we_o, win_valid_o, row_o, col_o, pad_mask_o, frame_done_o} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%b we=%b win=%b row=%0d col=%0d pad=%b done=%b, want all 0",
                     busy_o, lb_we_o, win_valid_o, row_o, col_o, pad_mask_o, frame_done_o);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({busy_o, lb_we_o, win_valid_o, frame_done_o} !== '0) begin
            fails++;
            $display("FAIL idle_after_reset: got busy=%b we=%b win=%b done=%b, want 0", busy_o, lb_we_o, win_valid_o, frame_done_o);
        end
    endtask

`ifndef LBC_BORDER_EN
    task automatic test_frame();
        int b, d0, dw0, dw1, se;
        b = win_cnt; d0 = done_cnt; dw0 = we0_cnt; dw1 = we1_cnt; se = seq_err;
        do_start();
        tests++;
        if (busy_o !== 1'b1) begin fails++; $display("FAIL busy_after_start: got %b want 1", busy_o); end
        drive_pix(20, 1'b0, 0);
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (win_cnt - b !== 6) begin fails++; $display("FAIL frame_win_count: got %0d want 6", win_cnt - b); end
        tests++;
        if (w_pix[b] !== 13 || w_row[b] !== 1 || w_col[b] !== 1 || w_pad[b] !== 0) begin
            fails++;
            $display("FAIL frame_first_win: got pix=%0d (%0d,%0d) pad=%0d want pix=13 (1,1) pad=0", w_pix[b], w_row[b], w_col[b], w_pad[b]);
        end
        tests++;
        if (w_row[b+5] !== 2 || w_col[b+5] !== 3 || w_done[b+5] !== 1) begin
            fails++;
            $display("FAIL frame_last_win: got (%0d,%0d) done=%0d want (2,3) done=1", w_row[b+5], w_col[b+5], w_done[b+5]);
        end
        tests++;
        if (done_cnt - d0 !== 1) begin fails++; $display("FAIL frame_done_count: got %0d want 1", done_cnt - d0); end
        tests++;
        if (we0_cnt - dw0 !== 20 || we1_cnt - dw1 !== 15) begin
            fails++;
            $display("FAIL frame_we_counts: got we0=%0d we1=%0d want 20 15", we0_cnt - dw0, we1_cnt - dw1);
        end
        tests++;
        if (busy_o !== 1'b0 || seq_err - se !== 0) begin
            fails++;
            $display("FAIL frame_busy_end: got busy=%b seq_err=%0d want 0 0", busy_o, seq_err - se);
        end
    endtask

    task automatic test_gaps();
        int b, dw0, dw1;
        b = win_cnt; dw0 = we0_cnt; dw1 = we1_cnt;
        do_start();
        drive_pix(20, 1'b1, 0);
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (win_cnt - b !== 6) begin fails++; $display("FAIL gaps_win_count: got %0d want 6", win_cnt - b); end
        for (int k = 0; k < 6; k++) begin
            tests++;
            if (w_row[b+k] !== 1 + k / 3 || w_col[b+k] !== 1 + k % 3) begin
                fails++;
                $display("FAIL gaps_win%0d: got (%0d,%0d) want (%0d,%0d)", k, w_row[b+k], w_col[b+k], 1 + k / 3, 1 + k % 3);
            end
        end
        tests++;
        if (w_done[b+5] !== 1) begin fails++; $display("FAIL gaps_done: got %0d want 1", w_done[b+5]); end
        tests++;
        if (we0_cnt - dw0 !== 20 || we1_cnt - dw1 !== 15) begin
            fails++;
            $display("FAIL gaps_we_counts: got we0=%0d we1=%0d want 20 15", we0_cnt - dw0, we1_cnt - dw1);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = done_cnt;
        do_start();
        drive_pix(9, 1'b0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({busy_o, lb_we_o, win_valid_o, row_o, col_o, pad_mask_o, frame_done_o} !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: got busy=%b we=%b win=%b row=%0d col=%0d done=%b want all 0",
                     busy_o, lb_we_o, win_valid_o, row_o, col_o, frame_done_o);
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (done_cnt - d0 !== 0 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL midreset_abort: got done=%0d busy=%b want 0 0", done_cnt - d0, busy_o);
        end
        test_frame();
    endtask

    task automatic test_idle_start();
        int b, d0, dw0;
        dw0 = we0_cnt;
        valid_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        valid_i = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (we0_cnt - dw0 !== 0 || idle_we_cnt !== 0) begin
            fails++;
            $display("FAIL idle_we: got we0=%0d idle_we=%0d want 0 0", we0_cnt - dw0, idle_we_cnt);
        end
        b = win_cnt; d0 = done_cnt; dw0 = we0_cnt;
        do_start();
        drive_pix(20, 1'b0, 8);
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (win_cnt - b !== 6 || done_cnt - d0 !== 1 || we0_cnt - dw0 !== 20) begin
            fails++;
            $display("FAIL run_start_ignored: got wins=%0d done=%0d we0=%0d want 6 1 20", win_cnt - b, done_cnt - d0, we0_cnt - dw0);
        end
        tests++;
        if (w_row[b+5] !== 2 || w_col[b+5] !== 3) begin
            fails++;
            $display("FAIL run_start_last: got (%0d,%0d) want (2,3)", w_row[b+5], w_col[b+5]);
        end
    endtask
`else
    task automatic test_border();
        int b, d0, dw0, d11;
        b = win_cnt; d0 = done_cnt; dw0 = we0_cnt; d11 = we11_cnt;
        do_start();
        drive_pix(20, 1'b0, 0);
        repeat (12) @(posedge clk);
        #1;
        tests++;
        if (win_cnt - b !== 20) begin fails++; $display("FAIL border_win_count: got %0d want 20", win_cnt - b); end
        tests++;
        if (w_pix[b] !== 7 || w_row[b] !== 0 || w_col[b] !== 0 || w_pad[b] !== 4'b1010) begin
            fails++;
            $display("FAIL border_first: got pix=%0d (%0d,%0d) pad=%b want 7 (0,0) 1010", w_pix[b], w_row[b], w_col[b], w_pad[b][3:0]);
        end
        for (int k = 0; k < 20; k++) begin
            tests++;
            if (w_row[b+k] !== k / W || w_col[b+k] !== k % W) begin
                fails++;
                $display("FAIL border_win%0d: got (%0d,%0d) want (%0d,%0d)", k, w_row[b+k], w_col[b+k], k / W, k % W);
            end
        end
        tests++;
        if (w_pad[b+19] !== 4'b0101 || w_done[b+19] !== 1) begin
            fails++;
            $display("FAIL border_last: got pad=%b done=%0d want 0101 1", w_pad[b+19][3:0], w_done[b+19]);
        end
        tests++;
        if (we11_cnt - d11 !== 21 || we0_cnt - dw0 !== 26) begin
            fails++;
            $display("FAIL border_flush_we: got we11=%0d we0=%0d want 21 26", we11_cnt - d11, we0_cnt - dw0);
        end
        tests++;
        if (done_cnt - d0 !== 1 || busy_o !== 1'b0 || seq_err !== 0) begin
            fails++;
            $display("FAIL border_end: got done=%0d busy=%b seq_err=%0d want 1 0 0", done_cnt - d0, busy_o, seq_err);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifndef LBC_BORDER_EN
        test_frame();
        test_gaps();
        test_reset_mid();
        test_idle_start();
`else
        test_border();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Sequencing controller for the Sobel front end. It counts the incoming pixel stream and drives the write enables of two cascaded single-line FIFO buffers. It also marks when the buffers plus the window registers hold a valid 3x3 neighbourhood, and reports the centre-pixel coordinates. It sits between the pixel source and the line-buffer/window datapath; the Sobel kernel consumes `win_valid_o`.

## Interface
- `WIDTH`, default 640: pixels per line; must be ≥ 3.
- `HEIGHT`, default 480: lines per frame; must be ≥ 3.
- `CW`, default `$clog2(WIDTH)`: column counter width.
- `RW`, default `$clog2(HEIGHT)`: row counter width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start_i` in 1: one-cycle pulse that arms a frame.
- `valid_i` in 1: pixel strobe from the source. The datapath registers `data_i` on the same edge.
- `busy_o` out 1: a frame is in progress.
- `lb_we_o` out 2: [0] write enable for line buffer 0, [1] for line buffer 1 (fed by buffer 0 output).
- `win_valid_o` out 1: the 3x3 window is valid this cycle.
- `row_o` out RW: row of the window centre.
- `col_o` out CW: column of the window centre.
- `pad_mask_o` out 4: {top, bottom, left, right} border flags for the window centre.
- `frame_done_o` out 1: one-cycle pulse marking the end of the frame.

## Operation
- States:
  - IDLE: all outputs low; `start_i` → FILL.
  - FILL: input row 0; the last pixel of row 0 → RUN.
  - RUN: rows 1..HEIGHT-1; the last pixel of the frame → FLUSH (macro defined) or IDLE (macro undefined).
  - FLUSH: issues exactly WIDTH+1 internal strobes, one per cycle, then → IDLE.
- Accepted pixel: `valid_i`=1 in FILL or RUN.
  - Ignored in IDLE and FLUSH.
  - `start_i` is ignored unless the state is IDLE.
- Input counters `in_col` and `in_row`:
  - Advance on every accepted pixel.
  - `in_col` wraps WIDTH-1 → 0 and increments `in_row` on the wrap.
  - Both clear on entry to FILL.
- `lb_we_o[0]` = 1 for every accepted pixel.
- `lb_we_o[1]` = 1 for accepted pixels with `in_row` ≥ 1.
- During a FLUSH strobe, `lb_we_o` = 2'b11; the datapath shifts zero.
- Interior mode (macro undefined):
  - `win_valid_o` for each accepted pixel with `in_row` ≥ 2 and `in_col` ≥ 2.
  - Centre coordinates: `row_o` = `in_row`-1, `col_o` = `in_col`-1.
  - Exactly (WIDTH-2)*(HEIGHT-2) windows per frame.
  - `pad_mask_o` = 0.
- A window is never emitted across a line wrap: `in_col` 0 and 1 never produce a window.
- `busy_o` = 1 in FILL, RUN and FLUSH.

## Timing
- Reset: state IDLE; all counters 0; `busy_o`, `lb_we_o`, `win_valid_o`, `row_o`, `col_o`, `pad_mask_o`, `frame_done_o` all 0.
- Reset mid-frame aborts immediately with no `frame_done_o`.
- All outputs are registered. `lb_we_o`, `win_valid_o`, `row_o`, `col_o` and `pad_mask_o` appear one cycle after the accepting edge (or the FLUSH strobe edge).
- `busy_o` rises the cycle after `start_i`.
- `frame_done_o` pulses in the same cycle as the final `win_valid_o`.
- `busy_o` falls in the cycle after that.
- `valid_i` may be deasserted at any time. Gaps stall the counters and outputs with no loss.
- If `start_i` and `valid_i` are high in the same IDLE cycle, the pixel is not accepted.

## Configuration
- `LBC_BORDER_EN` defined: full-frame mode.
  - Emits one window per frame pixel, WIDTH*HEIGHT in total.
  - The window centred at (r,c) is emitted on the acceptance of input index r*WIDTH+c+WIDTH+1.
  - Output counters `row_o`/`col_o` run 0..HEIGHT-1 / 0..WIDTH-1 independently of the input counters.
  - The remaining WIDTH+1 windows come from the FLUSH strobes.
  - `pad_mask_o` = {`row_o`==0, `row_o`==HEIGHT-1, `col_o`==0, `col_o`==WIDTH-1}.
- `LBC_BORDER_EN` undefined: interior mode only. There is no FLUSH state and `pad_mask_o` is tied to 0.

## Test plan
Benches use WIDTH=5, HEIGHT=4.
- Reset, then pulse `start_i` and drive 20 consecutive pixels (interior mode). Expect:
  - first `win_valid_o` the cycle after the 13th pixel, with `row_o`=1, `col_o`=1;
  - 6 windows in total;
  - the last window at (2,3) with `frame_done_o` in the same cycle.
- Same stimulus with `valid_i` toggling every other cycle: the same 6 windows with identical coordinates; `lb_we_o[0]` count = 20, `lb_we_o[1]` count = 15.
- `LBC_BORDER_EN`, 20 pixels. Expect:
  - first window after the 7th pixel at (0,0), `pad_mask_o`=4'b1010;
  - FLUSH lasts 6 cycles with `lb_we_o`=2'b11;
  - 20 windows in total;
  - the last at (3,4) with `pad_mask_o`=4'b0101 and `frame_done_o`.
- Assert `rst` after the 9th pixel: all outputs 0 on the next edge, no `frame_done_o`. A fresh `start_i` plus 20 pixels then repeats the first scenario exactly.
- `valid_i` driven in IDLE and `start_i` pulsed during RUN: no `lb_we_o` activity in IDLE, and the frame is unaffected (same window count as the first scenario).
